icache_fill_ctrl: RTL

Miss-handling controller between the instruction cache and the memory port. It accepts up to two line misses per cycle, merges duplicates into a small miss-status table (MSHR), and issues one memory request per cycle. Memory responses are matched by transaction tag and become registered line fills back to the icache. It sequences the read traffic generated by the fetch stage's two per-cycle line reads (`PC_aligned`, `PC_aligned+8`) and drops un-issued speculative misses on a fetch redirect.

---
 rtl/icache_fill_ctrl_if.sv | 33 +++
 rtl/icache_fill_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl_if.sv
// Signal bundle between the icache, the miss controller and the memory port.
// The slave modport is the controller's view; master is the icache/memory side.
interface icache_fill_ctrl_if #(
    parameter int TAG_BITS = 4
);
    logic [1:0]          miss_valid;
    logic [1:0][31:0]    miss_addr;
    logic [1:0]          miss_accepted;
    logic                flush;
    logic                mem_req_valid;
    logic [31:0]         mem_req_addr;
    logic [TAG_BITS-1:0] mem2proc_transaction_tag;
    logic [63:0]         mem2proc_data;
    logic [TAG_BITS-1:0] mem2proc_data_tag;
    logic                fill_valid;
    logic [31:0]         fill_addr;
    logic [63:0]         fill_data;
    logic                busy;

    modport slave (
        input  miss_valid, miss_addr, flush,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        output miss_accepted, mem_req_valid, mem_req_addr,
        output fill_valid, fill_addr, fill_data, busy
    );

    modport master (
        output miss_valid, miss_addr, flush,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        input  miss_accepted, mem_req_valid, mem_req_addr,
        input  fill_valid, fill_addr, fill_data, busy
    );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss controller: merges up to two misses per cycle into an MSHR
// table, issues one memory read per cycle and turns tagged responses into line fills.
module icache_fill_ctrl #(
    parameter int NUM_MSHR = 4,
    parameter int TAG_BITS = 4
) (
    input  logic              clock,
    input  logic              reset,
    icache_fill_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_MSHR);

    logic [NUM_MSHR-1:0] r_vld;
    logic [NUM_MSHR-1:0] r_iss;
    logic [28:0]         r_line [NUM_MSHR];
    logic [TAG_BITS-1:0] r_tag  [NUM_MSHR];
    logic                r_fill_valid;
    logic [31:0]         r_fill_addr;
    logic [63:0]         r_fill_data;
    logic                r_busy;

    logic [28:0]         w_line0;
    logic [28:0]         w_line1;
    logic                w_blocked;
    logic [1:0]          w_dup;
    logic                w_free0_ok;
    logic [IW-1:0]       w_free0_idx;
    logic                w_free1_ok;
    logic [IW-1:0]       w_free1_idx;
    logic                w_alloc0;
    logic                w_alloc1;
    logic [1:0]          w_acc;
    logic                w_iss_ok;
    logic [IW-1:0]       w_iss_idx;
    logic                w_req;
    logic                w_issue;
    logic                w_rsp_ok;
    logic [IW-1:0]       w_rsp_idx;
    logic [NUM_MSHR-1:0] w_vld_nxt;
    logic                w_unused_lsbs;

    assign w_line0       = bus.miss_addr[0][31:3];
    assign w_line1       = bus.miss_addr[1][31:3];
    assign w_unused_lsbs = ^{bus.miss_addr[0][2:0], bus.miss_addr[1][2:0]};
    assign w_blocked     = bus.flush | reset;

    // Entries being freed this cycle are still valid here, so a miss to them merges.
    always_comb begin
        w_dup[0] = r_fill_valid && (r_fill_addr[31:3] == w_line0);
        w_dup[1] = r_fill_valid && (r_fill_addr[31:3] == w_line1);
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (r_vld[i] && (r_line[i] == w_line0)) w_dup[0] = 1'b1;
            if (r_vld[i] && (r_line[i] == w_line1)) w_dup[1] = 1'b1;
        end
    end

    always_comb begin
        w_free0_ok  = 1'b0;
        w_free0_idx = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_free0_ok  = 1'b1;
                w_free0_idx = IW'(i);
            end
        end
    end

    assign w_alloc0 = bus.miss_valid[0] && !w_blocked && !w_dup[0] && w_free0_ok;

    always_comb begin
        w_free1_ok  = 1'b0;
        w_free1_idx = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (!r_vld[i] && !(w_alloc0 && (w_free0_idx == IW'(i)))) begin
                w_free1_ok  = 1'b1;
                w_free1_idx = IW'(i);
            end
        end
    end

    // Port 1 on the same new line as port 0 shares port 0's allocation.
    always_comb begin
        w_acc[0] = bus.miss_valid[0] && !w_blocked && (w_dup[0] || w_free0_ok);
        w_acc[1] = 1'b0;
        w_alloc1 = 1'b0;
        if (bus.miss_valid[1] && !w_blocked) begin
            if (w_dup[1]) begin
                w_acc[1] = 1'b1;
            end else if (bus.miss_valid[0] && (w_line0 == w_line1)) begin
                w_acc[1] = w_acc[0];
            end else begin
                w_alloc1 = w_free1_ok;
                w_acc[1] = w_free1_ok;
            end
        end
    end

    always_comb begin
        w_iss_ok  = 1'b0;
        w_iss_idx = '0;
        w_rsp_ok  = 1'b0;
        w_rsp_idx = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (r_vld[i] && !r_iss[i]) begin
                w_iss_ok  = 1'b1;
                w_iss_idx = IW'(i);
            end
            if (r_vld[i] && r_iss[i] && (bus.mem2proc_data_tag != '0) &&
                (r_tag[i] == bus.mem2proc_data_tag)) begin
                w_rsp_ok  = 1'b1;
                w_rsp_idx = IW'(i);
            end
        end
    end

    assign w_req   = w_iss_ok && !bus.flush;
    assign w_issue = w_req && (bus.mem2proc_transaction_tag != '0);

    always_comb begin
        w_vld_nxt = r_vld;
        if (bus.flush) w_vld_nxt = r_vld & r_iss;
        if (w_rsp_ok)  w_vld_nxt[w_rsp_idx]   = 1'b0;
        if (w_alloc0)  w_vld_nxt[w_free0_idx] = 1'b1;
        if (w_alloc1)  w_vld_nxt[w_free1_idx] = 1'b1;
    end

    // Response, issue and allocation always target distinct entries, so their writes never collide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld        <= '0;
            r_iss        <= '0;
            for (int i = 0; i < NUM_MSHR; i++) begin
                r_line[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_data  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_vld        <= w_vld_nxt;
            r_busy       <= |w_vld_nxt;
            r_fill_valid <= w_rsp_ok;
            if (w_rsp_ok) begin
                r_iss[w_rsp_idx] <= 1'b0;
                r_fill_addr      <= {r_line[w_rsp_idx], 3'b000};
                r_fill_data      <= bus.mem2proc_data;
            end
            if (w_issue) begin
                r_iss[w_iss_idx] <= 1'b1;
                r_tag[w_iss_idx] <= bus.mem2proc_transaction_tag;
            end
            if (w_alloc0) begin
                r_iss[w_free0_idx]  <= 1'b0;
                r_line[w_free0_idx] <= w_line0;
            end
            if (w_alloc1) begin
                r_iss[w_free1_idx]  <= 1'b0;
                r_line[w_free1_idx] <= w_line1;
            end
        end
    end

    assign bus.miss_accepted = w_acc;
    assign bus.mem_req_valid = w_req;
    assign bus.mem_req_addr  = w_req ? {r_line[w_iss_idx], 3'b000} : 32'h0;
    assign bus.fill_valid    = r_fill_valid;
    assign bus.fill_addr     = r_fill_addr;
    assign bus.fill_data     = r_fill_data;
    assign bus.busy          = r_busy;
endmodule
